uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 28 ++
 rtl/uart_rx.sv | 103 ++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver: FSM state encoding and default
// frame-format constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam int DBIT_DEF    = 8;
  localparam int SB_TICK_DEF = 16;
  localparam int OVERSAMPLE  = 16;

  // Tick counter must cover both a full data bit and the longest stop period.
  function automatic int s_width(input int sb_tick);
    return ($clog2(sb_tick) > 4) ? $clog2(sb_tick) : 4;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; both flops reset to
// RST_VAL so an idle-high line stays quiet through reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  // Metastability filter: first flop may go metastable, second resolves it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: samples each bit at its centre, shifts data
// LSB first and flags a low stop bit as a framing error.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEF,
  parameter int SB_TICK = SB_TICK_DEF
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  input  logic       s_tick,
  output logic       rx_done_tick,
  output logic [7:0] dout,
  output logic       frame_err
);

  localparam int            SW     = s_width(SB_TICK);
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP = SW'(SB_TICK - 1);
  localparam logic [2:0]    N_LAST = 3'(DBIT - 1);

  rx_state_e     r_state;
  logic [SW-1:0] r_s;
  logic [2:0]    r_n;
  logic [7:0]    r_b;
  logic          w_rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_rx_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx),
    .q       (w_rx_s)
  );

  // Receive FSM: idle detection runs every clk, everything else advances on s_tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_n     <= 3'd0;
      r_b     <= 8'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
            r_s     <= '0;
          end
        end
        START: begin
          if (s_tick) begin
            if (r_s == S_MID) begin
              if (!w_rx_s) begin
                r_state <= DATA;
                r_s     <= '0;
                r_n     <= 3'd0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (r_s == S_LAST) begin
              r_s <= '0;
              r_b <= {w_rx_s, r_b[7:1]};
              if (r_n == N_LAST) begin
                r_state <= STOP;
              end else begin
                r_n <= r_n + 3'd1;
              end
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        STOP: begin
          if (s_tick) begin
            if (r_s == S_STOP) begin
              r_state <= IDLE;
            end else begin
              r_s <= r_s + SW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign rx_done_tick = (r_state == STOP) && s_tick && (r_s == S_STOP);
  assign frame_err    = rx_done_tick & ~w_rx_s;
  // Bits enter at the MSB, so a short frame ends up in the upper DBIT bits.
  assign dout         = r_b >> (8 - DBIT);

endmodule
